// File: rtl/line_buffer_window_ctrl.sv
// Raster window-valid controller for KERNELxKERNEL / STRIDE line buffers; outputs registered 1 cycle after the pixel.
// No backpressure: every input_valid pixel in an active frame is consumed; gaps stall the position counters.
module line_buffer_window_ctrl #(
  parameter int IMG_W  = 6,
  parameter int IMG_H  = 6,
  parameter int KERNEL = 3,
  parameter int STRIDE = 1,
  parameter int CW     = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sof,
  input  logic          input_valid,
  output logic          output_valid,
  output logic [CW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          window_last,
  output logic          frame_done
);

  localparam int OUT_W = (IMG_W - KERNEL) / STRIDE + 1;
  localparam int OUT_H = (IMG_H - KERNEL) / STRIDE + 1;

  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] K_M1  = CW'(KERNEL - 1);
  localparam logic [CW-1:0] W_M1  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] H_M1  = CW'(IMG_H - 1);
  localparam logic [CW-1:0] S_M1  = CW'(STRIDE - 1);
  localparam logic [CW-1:0] OW    = CW'(OUT_W);
  localparam logic [CW-1:0] OH    = CW'(OUT_H);
  localparam logic [CW-1:0] OW_M1 = CW'(OUT_W - 1);
  localparam logic [CW-1:0] OH_M1 = CW'(OUT_H - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t state, state_nxt;

  logic [CW-1:0] col, row, col_ph, row_ph, wcol, wrow;
  logic [CW-1:0] c_col, c_row, c_col_ph, c_row_ph, c_wcol, c_wrow;
  logic          accept, col_end, row_end, last_px;
  logic          col_hit, row_hit, qualify, is_last_win;

  function automatic logic [CW-1:0] ph_next(input logic [CW-1:0] ph);
    return (ph == S_M1) ? '0 : ph + ONE;
  endfunction

  // sof makes the pixel of the same cycle position (0,0), so work from cleared copies
  assign c_col    = sof ? '0 : col;
  assign c_row    = sof ? '0 : row;
  assign c_col_ph = sof ? '0 : col_ph;
  assign c_row_ph = sof ? '0 : row_ph;
  assign c_wcol   = sof ? '0 : wcol;
  assign c_wrow   = sof ? '0 : wrow;

  assign accept      = input_valid && (sof || state == ACTIVE);
  assign col_end     = (c_col == W_M1);
  assign row_end     = (c_row == H_M1);
  assign last_px     = accept && col_end && row_end;
  assign col_hit     = (c_col >= K_M1) && (c_col_ph == '0);
  assign row_hit     = (c_row >= K_M1) && (c_row_ph == '0);
  assign qualify     = accept && col_hit && row_hit && (c_wcol < OW) && (c_wrow < OH);
  assign is_last_win = (c_wcol == OW_M1) && (c_wrow == OH_M1);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (sof)     state_nxt = ACTIVE;
    if (last_px) state_nxt = DONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col    <= '0;
      row    <= '0;
      col_ph <= '0;
      row_ph <= '0;
      wcol   <= '0;
      wrow   <= '0;
    end else if (sof || accept) begin
      col    <= c_col;
      row    <= c_row;
      col_ph <= c_col_ph;
      row_ph <= c_row_ph;
      wcol   <= c_wcol;
      wrow   <= c_wrow;
      if (accept) begin
        if (col_end) begin
          col    <= '0;
          col_ph <= '0;
          wcol   <= '0;
          row    <= c_row + ONE;
          if (c_row >= K_M1) row_ph <= ph_next(c_row_ph);
          if (row_hit)       wrow   <= c_wrow + ONE;
        end else begin
          col <= c_col + ONE;
          if (c_col >= K_M1) col_ph <= ph_next(c_col_ph);
          if (col_hit)       wcol   <= c_wcol + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      output_valid <= 1'b0;
      window_last  <= 1'b0;
      frame_done   <= 1'b0;
      out_row      <= '0;
      out_col      <= '0;
    end else begin
      output_valid <= qualify;
      window_last  <= qualify && is_last_win;
      frame_done   <= last_px;
      if (qualify) begin
        out_row <= c_wrow;
        out_col <= c_wcol;
      end
    end
  end

endmodule
